// File: rtl/sle_bist.sv
// Built-in self-test engine for an SLE storage element: drives LFSR vectors through
// async-load, flop and latch phases and checks the element's Q against an internal model.
module sle_bist #(
    parameter int          N_VECTORS = 100,
    parameter logic [7:0]  LFSR_SEED = 8'hA5,
    parameter int          ERR_W     = 8
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Q,
    output logic             D,
    output logic             En,
    output logic             SLn,
    output logic             SD,
    output logic             ALn,
    output logic             ADn,
    output logic             LAT,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       fail_phase,
    output logic [7:0]       fail_idx
);

    typedef enum logic [2:0] {
        S_IDLE, S_A_DRIVE, S_A_CHECK, S_F_DRIVE,
        S_F_CHECK, S_L_DRIVE, S_L_CHECK, S_DONE
    } state_t;

    state_t           r_state, w_state_next;
    logic [7:0]       r_lfsr, w_lfsr_next;
    logic [7:0]       r_idx, w_idx_next;
    logic             r_exp, w_exp_next;
    logic             r_d, r_en, r_sln, r_sd, r_aln, r_adn, r_lat;
    logic             w_d_next, w_en_next, w_sln_next, w_sd_next, w_aln_next, w_adn_next, w_lat_next;
    logic             r_busy, r_done, r_pass;
    logic             w_busy_next, w_done_next, w_pass_next;
    logic [ERR_W-1:0] r_err, w_err_next;
    logic [1:0]       r_fail_phase, w_fail_phase_next;
    logic [7:0]       r_fail_idx, w_fail_idx_next;

    logic [7:0]       w_lfsr_step;
    logic             w_vec_exp, w_chk_exp, w_mismatch, w_last_vec, w_in_check;
    logic [ERR_W-1:0] w_err_upd;
    logic [1:0]       w_chk_phase;
    logic [7:0]       w_chk_idx;

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1
    assign w_lfsr_step = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_vec_exp   = r_en ? (r_sln ? r_d : r_sd) : r_exp;
    assign w_chk_exp   = (r_state == S_A_CHECK) ? ~r_adn : w_vec_exp;
    assign w_mismatch  = (Q != w_chk_exp);
    assign w_last_vec  = (r_idx == 8'(N_VECTORS - 1));
    assign w_in_check  = (r_state == S_A_CHECK) || (r_state == S_F_CHECK) || (r_state == S_L_CHECK);
    assign w_err_upd   = (w_mismatch && (r_err != '1)) ? r_err + ERR_W'(1) : r_err;
    assign w_chk_phase = (r_state == S_A_CHECK) ? 2'd0 : (r_state == S_F_CHECK) ? 2'd1 : 2'd2;
    assign w_chk_idx   = (r_state == S_A_CHECK) ? 8'd0 : r_idx;

    always_ff @(posedge Clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_lfsr       <= LFSR_SEED;
            r_idx        <= 8'd0;
            r_exp        <= 1'b0;
            r_d          <= 1'b0;
            r_en         <= 1'b0;
            r_sln        <= 1'b0;
            r_sd         <= 1'b0;
            r_aln        <= 1'b1;
            r_adn        <= 1'b0;
            r_lat        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_fail_phase <= 2'd3;
            r_fail_idx   <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_lfsr       <= w_lfsr_next;
            r_idx        <= w_idx_next;
            r_exp        <= w_exp_next;
            r_d          <= w_d_next;
            r_en         <= w_en_next;
            r_sln        <= w_sln_next;
            r_sd         <= w_sd_next;
            r_aln        <= w_aln_next;
            r_adn        <= w_adn_next;
            r_lat        <= w_lat_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            r_pass       <= w_pass_next;
            r_err        <= w_err_next;
            r_fail_phase <= w_fail_phase_next;
            r_fail_idx   <= w_fail_idx_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_lfsr_next       = r_lfsr;
        w_idx_next        = r_idx;
        w_exp_next        = r_exp;
        w_d_next          = r_d;
        w_en_next         = r_en;
        w_sln_next        = r_sln;
        w_sd_next         = r_sd;
        w_aln_next        = r_aln;
        w_adn_next        = r_adn;
        w_lat_next        = r_lat;
        w_busy_next       = r_busy;
        w_done_next       = r_done;
        w_pass_next       = r_pass;
        w_err_next        = r_err;
        w_fail_phase_next = r_fail_phase;
        w_fail_idx_next   = r_fail_idx;

        // Only the first mismatch of a run records its location
        if (w_in_check) begin
            w_err_next = w_err_upd;
            if (w_mismatch && (r_fail_phase == 2'd3)) begin
                w_fail_phase_next = w_chk_phase;
                w_fail_idx_next   = w_chk_idx;
            end
        end

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_lfsr_next       = LFSR_SEED;
                    w_err_next        = '0;
                    w_done_next       = 1'b0;
                    w_pass_next       = 1'b0;
                    w_fail_phase_next = 2'd3;
                    w_fail_idx_next   = 8'd0;
                    w_busy_next       = 1'b1;
                    w_aln_next        = 1'b0;
                    w_adn_next        = LFSR_SEED[4];
                    w_lat_next        = 1'b0;
                    w_idx_next        = 8'd0;
                    w_state_next      = S_A_DRIVE;
                end else if (r_state == S_DONE) begin
                    w_state_next = S_IDLE;
                end
            end
            S_A_DRIVE: w_state_next = S_A_CHECK;
            S_A_CHECK: begin
                w_exp_next   = ~r_adn;
                w_aln_next   = 1'b1;
                w_lat_next   = 1'b0;
                w_lfsr_next  = w_lfsr_step;
                w_d_next     = w_lfsr_step[0];
                w_en_next    = w_lfsr_step[1];
                w_sln_next   = w_lfsr_step[2];
                w_sd_next    = w_lfsr_step[3];
                w_adn_next   = w_lfsr_step[4];
                w_idx_next   = 8'd0;
                w_state_next = S_F_DRIVE;
            end
            S_F_DRIVE: w_state_next = S_F_CHECK;
            S_L_DRIVE: w_state_next = S_L_CHECK;
            S_F_CHECK, S_L_CHECK: begin
                w_exp_next  = w_vec_exp;
                w_lfsr_next = w_lfsr_step;
                w_d_next    = w_lfsr_step[0];
                w_en_next   = w_lfsr_step[1];
                w_sln_next  = w_lfsr_step[2];
                w_sd_next   = w_lfsr_step[3];
                w_adn_next  = w_lfsr_step[4];
                if (!w_last_vec) begin
                    w_idx_next   = r_idx + 8'd1;
                    w_state_next = (r_state == S_F_CHECK) ? S_F_DRIVE : S_L_DRIVE;
                end else if (r_state == S_F_CHECK) begin
                    w_idx_next   = 8'd0;
                    w_lat_next   = 1'b1;
                    w_state_next = S_L_DRIVE;
                end else begin
                    w_idx_next   = 8'd0;
                    w_en_next    = 1'b0;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                    w_pass_next  = (w_err_upd == '0);
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign D          = r_d;
    assign En         = r_en;
    assign SLn        = r_sln;
    assign SD         = r_sd;
    assign ALn        = r_aln;
    assign ADn        = r_adn;
    assign LAT        = r_lat;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign fail_phase = r_fail_phase;
    assign fail_idx   = r_fail_idx;

endmodule

// File: tb/tb_sle_bist.sv
// Self-checking bench for sle_bist: behavioural SLE on Q (with fault modes) and a
// vector-list reference model predicting error count and first-failure location.
module tb_sle_bist;

    localparam int         NV   = 100;
    localparam logic [7:0] SEED = 8'hA5;
    localparam int         NV2  = 10;

    logic Clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic Q, D, En, SLn, SD, ALn, ADn, LAT, busy, done, pass;
    logic [7:0] err_count, fail_idx;
    logic [1:0] fail_phase;
    logic Q2, D2, En2, SLn2, SD2, ALn2, ADn2, LAT2, busy2, done2, pass2;
    logic [3:0] err_count2;
    logic [7:0] fail_idx2;
    logic [1:0] fail_phase2;

    int   checks = 0;
    int   errors = 0;
    int   qmode  = 0;
    logic flip   = 1'b0;
    int   cyc;
    bit   corrupt [0:2*NV];

    always #5 Clk = ~Clk;

    sle_bist #(.N_VECTORS(NV), .LFSR_SEED(SEED), .ERR_W(8)) dut (
        .Clk(Clk), .rst(rst), .start(start), .Q(Q),
        .D(D), .En(En), .SLn(SLn), .SD(SD), .ALn(ALn), .ADn(ADn), .LAT(LAT),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_phase(fail_phase), .fail_idx(fail_idx)
    );

    sle_bist #(.N_VECTORS(NV2), .LFSR_SEED(SEED), .ERR_W(4)) dut2 (
        .Clk(Clk), .rst(rst), .start(start2), .Q(Q2),
        .D(D2), .En(En2), .SLn(SLn2), .SD(SD2), .ALn(ALn2), .ADn(ADn2), .LAT(LAT2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
        .fail_phase(fail_phase2), .fail_idx(fail_idx2)
    );

    // Behavioural SLE: async load of ~ADn, transparent when LAT&&En, else edge-loaded storage
    logic g_q_r, g_q, g2_q_r, g2_q;
    always @(posedge Clk) begin
        if (!ALn)    g_q_r <= ~ADn;
        else if (En) g_q_r <= SLn ? D : SD;
        if (!ALn2)    g2_q_r <= ~ADn2;
        else if (En2) g2_q_r <= SLn2 ? D2 : SD2;
    end
    assign g_q  = !ALn  ? ~ADn  : (LAT  && En)  ? (SLn  ? D  : SD)  : g_q_r;
    assign g2_q = !ALn2 ? ~ADn2 : (LAT2 && En2) ? (SLn2 ? D2 : SD2) : g2_q_r;

    // qmode: 0 golden, 1 tied low, 2 non-inverting async load, 3 golden with random flips
    assign Q  = (qmode == 1) ? 1'b0 : (qmode == 2 && !ALn) ? ADn : (g_q ^ flip);
    assign Q2 = ~g2_q;

    typedef struct {
        int mode;
        int exp_err;
        int exp_ph;
        int exp_idx;
        int exp_pass;
        bit err_min_only;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, req);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int req);
        checks++;
        if (act < req) begin
            errors++;
            $display("FAIL %s got %0d want >= %0d", name, act, req);
        end
    endtask

    // Reference: enumerate the run as a list of checks and expected values
    function automatic void ref_run(input int mode, output int err, output int ph, output int idx);
        logic [7:0] l;
        logic       e, q;
        l   = SEED;
        e   = 1'b0;
        err = 0;
        ph  = 3;
        idx = 0;
        for (int j = 0; j <= 2 * NV; j++) begin
            if (j == 0)     e = ~l[4];
            else if (l[1])  e = l[2] ? l[0] : l[3];
            q = (mode == 1) ? 1'b0 : (mode == 3) ? (e ^ corrupt[j]) : e;
            if (q != e) begin
                if (err < 255) err++;
                if (ph == 3) begin
                    ph  = (j == 0) ? 0 : (j <= NV) ? 1 : 2;
                    idx = (j == 0) ? 0 : (j - 1) % NV;
                end
            end
            l = {l[6:0], ^(l & 8'hB8)};
        end
    endfunction

    // One run from start (cycle 0); optional extra start pulses s1/s2 and reset at cycle rc
    task automatic run_dut(input int mode, input int s1, input int s2, input int rc,
                           output int busy_cnt, output int done_cyc);
        logic [7:0] sv;
        sv       = SEED;
        busy_cnt = 0;
        done_cyc = -1;
        @(negedge Clk);
        qmode = mode;
        flip  = 1'b0;
        start = 1'b1;
        cyc   = 0;
        while (cyc < 1000 && done_cyc < 0 && !(rc >= 0 && cyc > rc)) begin
            @(posedge Clk);
            #1;
            cyc++;
            start = (cyc == s1) || (cyc == s2);
            rst   = (cyc == rc);
            flip  = (mode == 3 && ((cyc - 1) / 2) <= 2 * NV) ? corrupt[(cyc - 1) / 2] : 1'b0;
            if (cyc == 1) begin
                chk("busy_at_1", int'(busy), 1);
                chk("done_clr_at_1", int'(done), 0);
                chk("aln_at_1", int'(ALn), 0);
                chk("adn_at_1", int'(ADn), int'(sv[4]));
            end
            if (busy) busy_cnt++;
            if (done && done_cyc < 0) done_cyc = cyc;
            if (rc >= 0 && cyc == rc + 1) begin
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_aln", int'(ALn), 1);
                chk("rst_en", int'(En), 0);
                chk("rst_err", int'(err_count), 0);
                chk("rst_phase", int'(fail_phase), 3);
            end
        end
        start = 1'b0;
        rst   = 1'b0;
        flip  = 1'b0;
        $display("run mode=%0d busy=%0d done_at=%0d err=%0d phase=%0d idx=%0d pass=%0d",
                 mode, busy_cnt, done_cyc, err_count, fail_phase, fail_idx, pass);
    endtask

    initial begin
        int e, p, x, bc, dc;

        for (int i = 0; i <= 2 * NV; i++) corrupt[i] = ($urandom_range(0, 3) == 0);

        tbl[0] = '{0, 0, 3, 0, 1, 1'b0};
        ref_run(1, e, p, x);
        tbl[1] = '{1, e, p, x, (e == 0) ? 1 : 0, 1'b0};
        tbl[2] = '{2, 1, 0, 0, 0, 1'b1};
        ref_run(3, e, p, x);
        tbl[3] = '{3, e, p, x, (e == 0) ? 1 : 0, 1'b0};

        repeat (3) @(posedge Clk);
        #1;
        chk("reset_D", int'(D), 0);
        chk("reset_En", int'(En), 0);
        chk("reset_SLn", int'(SLn), 0);
        chk("reset_SD", int'(SD), 0);
        chk("reset_ALn", int'(ALn), 1);
        chk("reset_ADn", int'(ADn), 0);
        chk("reset_LAT", int'(LAT), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_pass", int'(pass), 0);
        chk("reset_err", int'(err_count), 0);
        chk("reset_phase", int'(fail_phase), 3);
        chk("reset_idx", int'(fail_idx), 0);
        rst = 1'b0;

        for (int t = 0; t < 4; t++) begin
            run_dut(tbl[t].mode, -1, -1, -1, bc, dc);
            chk("busy_len", bc, 2 + 4 * NV);
            chk("done_at", dc, 3 + 4 * NV);
            if (tbl[t].err_min_only) chk_ge("err_count", int'(err_count), tbl[t].exp_err);
            else                     chk("err_count", int'(err_count), tbl[t].exp_err);
            chk("fail_phase", int'(fail_phase), tbl[t].exp_ph);
            chk("fail_idx", int'(fail_idx), tbl[t].exp_idx);
            chk("pass", int'(pass), tbl[t].exp_pass);
            repeat (3) @(posedge Clk);
            #1;
            chk("done_held", int'(done), 1);
        end

        // Reset mid-run, then a clean rerun must reproduce the full result
        run_dut(1, -1, -1, 50, bc, dc);
        run_dut(1, -1, -1, -1, bc, dc);
        chk("rerun_busy_len", bc, 2 + 4 * NV);
        chk("rerun_err", int'(err_count), tbl[1].exp_err);
        chk("rerun_phase", int'(fail_phase), tbl[1].exp_ph);
        chk("rerun_idx", int'(fail_idx), tbl[1].exp_idx);

        // Start pulses while busy are ignored
        run_dut(0, 10, 200, -1, bc, dc);
        chk("restart_busy_len", bc, 2 + 4 * NV);
        chk("restart_done_at", dc, 403);
        chk("restart_pass", int'(pass), 1);

        // Start coinciding with the cycle done rises is ignored
        run_dut(0, 2 + 4 * NV, -1, -1, bc, dc);
        chk("late_done_at", dc, 403);
        @(posedge Clk);
        #1;
        chk("late_start_busy", int'(busy), 0);
        chk("late_start_done", int'(done), 1);

        // Narrow counter: every check mismatches, count must stick at 15
        @(negedge Clk);
        start2 = 1'b1;
        bc = 0;
        dc = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge Clk);
            #1;
            start2 = 1'b0;
            if (busy2) bc++;
            if (done2) begin
                dc = k;
                break;
            end
        end
        $display("run dut2 busy=%0d done_at=%0d err=%0d phase=%0d pass=%0d",
                 bc, dc, err_count2, fail_phase2, pass2);
        chk("sat_busy_len", bc, 2 + 4 * NV2);
        chk("sat_done_at", dc, 3 + 4 * NV2);
        chk("sat_err", int'(err_count2), 15);
        chk("sat_pass", int'(pass2), 0);
        chk("sat_phase", int'(fail_phase2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sle_bist.md
Name: sle_bist

Overview:
- Hardware self-test engine for the SLE configurable storage element (flip-flop/latch with async load, enable, and sync load).
- Generates pseudo-random SLE stimulus from an LFSR and drives the element's inputs.
- Models the expected Q internally, samples the element's Q, and reports pass/fail, error count and first-failure location.
- Sits beside an SLE instance as its on-chip stimulus/checker.

Parameters:
- N_VECTORS, 100, vectors per mode phase (LAT=0 phase, then LAT=1 phase); range 1..255.
- LFSR_SEED, 8'hA5, LFSR load value on start; must be non-zero.
- ERR_W, 8, width of the error counter.

Ports:
- Clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a test run.
- Q  in  1  SLE output under test.
- D  out  1  SLE data input.
- En  out  1  SLE enable.
- SLn  out  1  SLE sync-load select, active-low.
- SD  out  1  SLE sync-load data.
- ALn  out  1  SLE async load, active-low.
- ADn  out  1  SLE async-load data.
- LAT  out  1  SLE mode select: 0 = flop, 1 = latch.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next accepted start.
- pass  out  1  done && err_count==0.
- err_count  out  ERR_W  mismatch count; saturates at all-ones.
- fail_phase  out  2  phase of the first mismatch: 0 = ASYNC, 1 = FLOP, 2 = LATCH, 3 = none.
- fail_idx  out  8  vector index within fail_phase of the first mismatch.

Behaviour:
- All outputs are registered.
- Reset values: D=En=SLn=SD=ADn=LAT=0, ALn=1, busy=done=pass=0, err_count=0, fail_phase=3, fail_idx=0, FSM=IDLE, lfsr=LFSR_SEED.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It shifts once per vector, on leaving the CHECK state.
- Vector mapping: D=lfsr[0], En=lfsr[1], SLn=lfsr[2], SD=lfsr[3], ADn=lfsr[4].
- Every vector takes 2 cycles:
  - DRIVE: outputs updated and held stable for a full clock period, so both flop and transparent-latch modes settle.
  - CHECK: Q sampled at the rising edge that ends CHECK and compared to exp.
- Expected model:
  - ASYNC phase: exp = ~ADn.
  - Otherwise: exp <= En ? (SLn ? D : SD) : exp, with exp carried across vectors and across the FLOP→LATCH boundary.
- FSM states and transitions:
  - IDLE: on start (with rst low), load lfsr=LFSR_SEED, clear err_count/done/pass, set fail_phase=3, busy=1 → A_DRIVE.
  - A_DRIVE: ALn=0, ADn=lfsr[4] → A_CHECK.
  - A_CHECK: compare Q to ~ADn; ALn stays 0 through this cycle → F_DRIVE with ALn=1, LAT=0, exp initialised to ~ADn.
  - F_DRIVE / F_CHECK: N_VECTORS vectors with LAT=0; after the last vector → L_DRIVE with LAT=1.
  - L_DRIVE / L_CHECK: N_VECTORS vectors with LAT=1; after the last vector → DONE.
  - DONE: busy=0, done=1, pass updated in the same cycle; En=0 → IDLE.
- Total run length: busy is high for exactly 2+4*N_VECTORS cycles (402 at default). done rises on the following cycle.
- Mismatch handling: err_count increments, saturating at 2^ERR_W-1. fail_phase/fail_idx latch only on the first mismatch of a run.
- start while busy: ignored.
- start in the same cycle done would rise: ignored.
- start while done=1: accepted and begins a new run.
- rst mid-run: on the next edge, all state returns to reset values, with ALn=1 and En=0 in that same cycle. No partial result is retained.
- Runs are fully deterministic for a given LFSR_SEED.

Test Plan:
- Golden SLE model on Q, defaults, pulse start → busy high 402 cycles; then done=1, pass=1, err_count=0, fail_phase=3.
- Q tied 0 → err_count = number of checks where the bench's model exp=1; pass=0; fail_phase/fail_idx = first such check, computed by the bench model.
- SLE model with non-inverting async load (Q=ADn) → fail_phase=0, fail_idx=0, err_count≥1, pass=0.
- ERR_W=4, Q tied to ~exp → err_count saturates at 15 and does not wrap; pass=0.
- rst asserted at cycle 50 of a run → next cycle busy=0, done=0, ALn=1, En=0, err_count=0. A new start reproduces the identical 402-cycle result.
- start pulsed at cycles 10 and 200 of a run → only one run executes; done rises exactly 403 cycles after the first start.
